dcache_nway: RTL and testbench

DCACHE_NWAY -- requirements
Module: dcache_nway

---
 rtl/dcache_nway_if.sv | 27 ++
 rtl/dcache_nway.sv | 192 +++++++++++++++++++
 tb/tb_dcache_nway.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_nway_if.sv
// CPU-side and memory-side bus bundle for the n-way data cache.
// slave  : the cache itself (takes CPU requests, issues memory requests).
// master : the surrounding CPU + memory environment.
interface dcache_nway_if;
   logic [31:0]  p1_addr_i;
   logic [31:0]  p1_data_i;
   logic         p1_MemRead_i;
   logic         p1_MemWrite_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic [255:0] mem_data_o;
   logic [31:0]  mem_addr_o;
   logic         mem_enable_o;
   logic         mem_write_o;

   modport slave (
      input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
      output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
   );

   modport master (
      output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
      input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
   );
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with exact LRU replacement.
// 256-bit lines, blocking miss handling (write-back then refill), one
// outstanding memory transaction at a time.
module dcache_nway #(
   parameter int WAYS = 2,
   parameter int SETS = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   dcache_nway_if.slave bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 27 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [WAY_W-1:0] AGE_OLDEST = WAY_W'(WAYS - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_REFILL    = 2'd2,
      ST_RESOLVE   = 2'd3
   } state_t;

   // Per-way / per-set storage
   logic               r_valid [WAYS][SETS];
   logic               r_dirty [WAYS][SETS];
   logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
   logic [WAY_W-1:0]   r_age   [WAYS][SETS];
   logic [255:0]       r_data  [WAYS][SETS];

   state_t             r_state;
   logic [WAY_W-1:0]   r_victim;
   logic               r_mem_en;
   logic               r_mem_we;
   logic [31:0]        r_mem_addr;
   logic [255:0]       r_mem_data;

   // Request decode
   logic               w_req;
   logic               w_write;
   logic [IDX_W-1:0]   w_index;
   logic [TAG_W-1:0]   w_tag;
   logic [2:0]         w_word;
   logic               w_unused_addr_bits;

   assign w_req              = bus.p1_MemRead_i | bus.p1_MemWrite_i;
   assign w_write            = bus.p1_MemWrite_i;   // read+write together is a write
   assign w_index            = bus.p1_addr_i[4+IDX_W:5];
   assign w_tag              = bus.p1_addr_i[31:5+IDX_W];
   assign w_word             = bus.p1_addr_i[4:2];
   assign w_unused_addr_bits = ^bus.p1_addr_i[1:0];

   // Tag lookup, hit way selection and victim choice
   logic [WAYS-1:0]    w_match;
   logic [WAYS-1:0]    w_invalid;
   logic [WAYS-1:0]    w_oldest;
   logic [WAY_W-1:0]   w_hit_way;
   logic [WAY_W-1:0]   w_inv_way;
   logic [WAY_W-1:0]   w_old_way;
   logic [WAY_W-1:0]   w_victim;
   logic [WAY_W-1:0]   w_hit_age;
   logic               w_hit;

   // Per-way compare vectors and lowest-index priority picks
   always_comb begin
      w_match   = {WAYS{1'b0}};
      w_invalid = {WAYS{1'b0}};
      w_oldest  = {WAYS{1'b0}};
      w_hit_way = {WAY_W{1'b0}};
      w_inv_way = {WAY_W{1'b0}};
      w_old_way = {WAY_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         w_match[w]   = r_valid[w][w_index] && (r_tag[w][w_index] == w_tag);
         w_invalid[w] = ~r_valid[w][w_index];
         w_oldest[w]  = (r_age[w][w_index] == AGE_OLDEST);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         w_hit_way = w_match[w]   ? WAY_W'(w) : w_hit_way;
         w_inv_way = w_invalid[w] ? WAY_W'(w) : w_inv_way;
         w_old_way = w_oldest[w]  ? WAY_W'(w) : w_old_way;
      end
      w_victim  = (|w_invalid) ? w_inv_way : w_old_way;
      w_hit_age = r_age[w_hit_way][w_index];
      // A held request only counts as a hit once the FSM is back in IDLE
      w_hit     = w_req && (r_state == ST_IDLE) && (|w_match);
   end

   // Combinational CPU read data: the addressed word on a read hit, else zero
   always_comb begin
      if (w_hit && !w_write) begin
         bus.p1_data_o = r_data[w_hit_way][w_index][{w_word, 5'b00000} +: 32];
      end else begin
         bus.p1_data_o = 32'h0000_0000;
      end
   end

   assign bus.p1_stall_o   = w_req & ~w_hit;
   assign bus.mem_enable_o = r_mem_en;
   assign bus.mem_write_o  = r_mem_we;
   assign bus.mem_addr_o   = r_mem_addr;
   assign bus.mem_data_o   = r_mem_data;

   // Line data array: write-hit word merge and refill install (not reset)
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_hit && w_write) begin
         r_data[w_hit_way][w_index][{w_word, 5'b00000} +: 32] <= bus.p1_data_i;
      end else if (!rst_i && (r_state == ST_REFILL) && bus.mem_ack_i) begin
         r_data[r_victim][w_index] <= bus.mem_data_i;
      end
   end

   // Miss FSM with registered memory-port outputs, plus valid/dirty/tag/age upkeep
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_victim   <= {WAY_W{1'b0}};
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= 32'h0000_0000;
         r_mem_data <= 256'd0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               r_valid[w][s] <= 1'b0;
               r_dirty[w][s] <= 1'b0;
               r_age[w][s]   <= WAY_W'(w);
            end
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  // Exact LRU: hit way becomes MRU, younger ways age by one
                  for (int w = 0; w < WAYS; w++) begin
                     if (WAY_W'(w) == w_hit_way) begin
                        r_age[w][w_index] <= {WAY_W{1'b0}};
                     end else if (r_age[w][w_index] < w_hit_age) begin
                        r_age[w][w_index] <= r_age[w][w_index] + 1'b1;
                     end
                  end
                  if (w_write) begin
                     r_dirty[w_hit_way][w_index] <= 1'b1;
                  end
               end else if (w_req) begin
                  r_victim <= w_victim;
                  r_mem_en <= 1'b1;
                  if (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index]) begin
                     r_state    <= ST_WRITEBACK;
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= {r_tag[w_victim][w_index], w_index, 5'b00000};
                     r_mem_data <= r_data[w_victim][w_index];
                  end else begin
                     r_state    <= ST_REFILL;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= {w_tag, w_index, 5'b00000};
                     r_mem_data <= 256'd0;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (bus.mem_ack_i) begin
                  r_state    <= ST_REFILL;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {w_tag, w_index, 5'b00000};
                  r_mem_data <= 256'd0;
               end
            end
            ST_REFILL: begin
               if (bus.mem_ack_i) begin
                  r_valid[r_victim][w_index] <= 1'b1;
                  r_dirty[r_victim][w_index] <= 1'b0;
                  r_tag[r_victim][w_index]   <= w_tag;
                  r_state    <= ST_RESOLVE;
                  r_mem_en   <= 1'b0;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= 32'h0000_0000;
                  r_mem_data <= 256'd0;
               end
            end
            ST_RESOLVE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_mem_en   <= 1'b0;
               r_mem_we   <= 1'b0;
               r_mem_addr <= 32'h0000_0000;
               r_mem_data <= 256'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (WAYS=2, SETS=16) with a scoreboard:
// stimulus pushes expected CPU read data and memory requests, a negedge
// monitor pops and compares them as the DUT presents them.
module tb_dcache_nway;
   logic clk;
   logic rst_i;
   logic mem_ack_r;
   logic spurious_ack;

   dcache_nway_if bus ();

   dcache_nway #(.WAYS(2), .SETS(16)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   assign bus.mem_ack_i = mem_ack_r | spurious_ack;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 CPU read data, 1 refill request, 2 write-back request
      logic [31:0] addr;
      logic [31:0] data;   // read word / write-back word 1 / 0 for refill
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   logic [255:0] mem_model [logic [31:0]];

   // Backing memory contents before any write-back: word at byte a is A5A5_<a[15:0]>
   function automatic logic [255:0] default_line(input logic [31:0] a);
      logic [255:0] l;
      logic [31:0]  wa;
      for (int k = 0; k < 8; k++) begin
         wa = a + 32'(k * 4);
         l[k*32 +: 32] = {16'hA5A5, wa[15:0]};
      end
      return l;
   endfunction

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic compare_ev(input string nm, input int k, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: unexpected kind %0d addr %0h data %0h, nothing expected", nm, k, a, d);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != k || e.addr !== a || e.data !== d) begin
            miscompares++;
            $display("FAIL %s: got kind %0d addr %0h data %0h expected kind %0d addr %0h data %0h",
                     nm, k, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Memory model: counts 10 enabled cycles, then one-cycle ack (driven on negedge)
   initial begin
      int cnt;
      cnt = 0;
      mem_ack_r = 1'b0;
      bus.mem_data_i = 256'd0;
      forever begin
         @(negedge clk);
         if (mem_ack_r) begin
            mem_ack_r = 1'b0;
            bus.mem_data_i = 256'd0;
            cnt = 0;
         end else if (rst_i || !bus.mem_enable_o) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt == 10) begin
               if (bus.mem_write_o) begin
                  mem_model[bus.mem_addr_o] = bus.mem_data_o;
               end else if (mem_model.exists(bus.mem_addr_o)) begin
                  bus.mem_data_i = mem_model[bus.mem_addr_o];
               end else begin
                  bus.mem_data_i = default_line(bus.mem_addr_o);
               end
               mem_ack_r = 1'b1;
            end
         end
      end
   end

   // Monitor: pop/compare on CPU read hits and on each new memory request
   initial begin
      logic        prev_en;
      logic        prev_we;
      logic [31:0] prev_addr;
      prev_en = 1'b0;
      prev_we = 1'b0;
      prev_addr = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.p1_MemRead_i && !bus.p1_MemWrite_i && !bus.p1_stall_o) begin
            compare_ev("sb_cpu_read", 0, bus.p1_addr_i, bus.p1_data_o);
         end
         if (bus.mem_enable_o && (!prev_en || bus.mem_write_o != prev_we || bus.mem_addr_o != prev_addr)) begin
            if (bus.mem_write_o) begin
               compare_ev("sb_writeback", 2, bus.mem_addr_o, bus.mem_data_o[63:32]);
            end else begin
               compare_ev("sb_refill", 1, bus.mem_addr_o, 32'h0);
            end
         end
         prev_en = bus.mem_enable_o;
         prev_we = bus.mem_write_o;
         prev_addr = bus.mem_addr_o;
      end
   end

   // One CPU access held until it hits; checks the first-cycle stall value
   task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] d,
                         input logic exp_miss, input string nm);
      int n;
      @(posedge clk); #1;
      bus.p1_addr_i = a;
      bus.p1_data_i = d;
      bus.p1_MemRead_i = ~wr;
      bus.p1_MemWrite_i = wr;
      @(negedge clk);
      chk({nm, "_first_stall"}, {255'd0, bus.p1_stall_o}, {255'd0, exp_miss});
      n = 0;
      while (bus.p1_stall_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.p1_stall_o) begin
         chk({nm, "_timeout"}, 256'd1, 256'd0);
      end
      @(posedge clk); #1;
      bus.p1_MemRead_i = 1'b0;
      bus.p1_MemWrite_i = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_i = 1'b1;
      bus.p1_MemRead_i = 1'b0;
      bus.p1_MemWrite_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int n;
      rst_i = 1'b1;
      spurious_ack = 1'b0;
      bus.p1_addr_i = 32'h0;
      bus.p1_data_i = 32'h0;
      bus.p1_MemRead_i = 1'b0;
      bus.p1_MemWrite_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_p1_data",  {224'd0, bus.p1_data_o},  256'd0);
      chk("rst_stall",    {255'd0, bus.p1_stall_o}, 256'd0);
      chk("rst_mem_en",   {255'd0, bus.mem_enable_o}, 256'd0);
      chk("rst_mem_we",   {255'd0, bus.mem_write_o},  256'd0);
      chk("rst_mem_addr", {224'd0, bus.mem_addr_o},   256'd0);
      chk("rst_mem_data", bus.mem_data_o,             256'd0);

      // Cold read miss: refill only, then word 0
      expect_ev(1, 32'h0000_0000, 32'h0);
      expect_ev(0, 32'h0000_0000, 32'hA5A5_0000);
      access(32'h0000_0000, 1'b0, 32'h0, 1'b1, "rd0_cold");

      // Write hit, then read-back
      access(32'h0000_0004, 1'b1, 32'h1234_5678, 1'b0, "wr4_hit");
      expect_ev(0, 32'h0000_0004, 32'h1234_5678);
      access(32'h0000_0004, 1'b0, 32'h0, 1'b0, "rd4_hit");

      // Fill way 1, then evict dirty way 0
      expect_ev(1, 32'h0000_0200, 32'h0);
      expect_ev(0, 32'h0000_0200, 32'hA5A5_0200);
      access(32'h0000_0200, 1'b0, 32'h0, 1'b1, "rd200");
      expect_ev(2, 32'h0000_0000, 32'h1234_5678);
      expect_ev(1, 32'h0000_0400, 32'h0);
      expect_ev(0, 32'h0000_0400, 32'hA5A5_0400);
      access(32'h0000_0400, 1'b0, 32'h0, 1'b1, "rd400_wb");
      // Written-back word comes back from memory (evicts clean 0x200)
      expect_ev(1, 32'h0000_0000, 32'h0);
      expect_ev(0, 32'h0000_0004, 32'h1234_5678);
      access(32'h0000_0004, 1'b0, 32'h0, 1'b1, "rd4_refetch");

      // LRU order with clean lines
      do_reset();
      expect_ev(1, 32'h0000_0000, 32'h0);
      expect_ev(0, 32'h0000_0000, 32'hA5A5_0000);
      access(32'h0000_0000, 1'b0, 32'h0, 1'b1, "lru_rd0");
      expect_ev(1, 32'h0000_0200, 32'h0);
      expect_ev(0, 32'h0000_0200, 32'hA5A5_0200);
      access(32'h0000_0200, 1'b0, 32'h0, 1'b1, "lru_rd200");
      expect_ev(0, 32'h0000_0000, 32'hA5A5_0000);
      access(32'h0000_0000, 1'b0, 32'h0, 1'b0, "lru_rd0_hit");
      expect_ev(1, 32'h0000_0400, 32'h0);
      expect_ev(0, 32'h0000_0400, 32'hA5A5_0400);
      access(32'h0000_0400, 1'b0, 32'h0, 1'b1, "lru_rd400");
      expect_ev(0, 32'h0000_0000, 32'hA5A5_0000);
      access(32'h0000_0000, 1'b0, 32'h0, 1'b0, "lru_rd0_kept");
      expect_ev(0, 32'h0000_0400, 32'hA5A5_0400);
      access(32'h0000_0400, 1'b0, 32'h0, 1'b0, "lru_rd400_hit");

      // Reset during refill aborts it
      do_reset();
      expect_ev(1, 32'h0000_0000, 32'h0);
      @(posedge clk); #1;
      bus.p1_addr_i = 32'h0000_0000;
      bus.p1_MemRead_i = 1'b1;
      @(negedge clk);
      chk("abort_first_stall", {255'd0, bus.p1_stall_o}, 256'd1);
      n = 0;
      while (!bus.mem_enable_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_refill_active", {254'd0, bus.mem_enable_o, bus.mem_write_o}, 256'd2);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_i = 1'b1;
      bus.p1_MemRead_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_mem_en", {255'd0, bus.mem_enable_o}, 256'd0);
      chk("abort_stall",  {255'd0, bus.p1_stall_o},  256'd0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      expect_ev(1, 32'h0000_0000, 32'h0);
      expect_ev(0, 32'h0000_0000, 32'hA5A5_0000);
      access(32'h0000_0000, 1'b0, 32'h0, 1'b1, "abort_reread");

      // Spurious ack in IDLE with no request
      @(posedge clk); #1;
      spurious_ack = 1'b1;
      @(posedge clk); #1;
      spurious_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("spur_mem_en", {255'd0, bus.mem_enable_o}, 256'd0);
         chk("spur_stall",  {255'd0, bus.p1_stall_o},  256'd0);
      end
      expect_ev(0, 32'h0000_0008, 32'hA5A5_0008);
      access(32'h0000_0008, 1'b0, 32'h0, 1'b0, "spur_rd8_hit");

      repeat (5) @(negedge clk);
      chk("sb_leftover", 256'(sb_q.size()), 256'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
